mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Microcode address sequencer: next-address selection, bounded return stack,
// and single-level vectored interrupt entry with a sticky pending register.
module mc_sequencer #(
    parameter int AW    = 11,
    parameter int SD    = 4,
    parameter int NIRQ  = 8,
    parameter int VBASE = 2**AW - 2*NIRQ
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       EN,
    input  logic [2:0]                 OP,
    input  logic [AW-1:0]              TARGET,
    input  logic                       COND,
    input  logic [NIRQ-1:0]            REQ,
    input  logic [NIRQ-1:0]            IMASK,
    output logic [AW-1:0]              ADDR,
    output logic [NIRQ-1:0]            IACK,
    output logic                       INTACT,
    output logic [$clog2(SD+1)-1:0]    DEPTH,
    output logic                       OVF,
    output logic                       UNF
);

    localparam int DW = $clog2(SD + 1);

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JCC  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_IRET = 3'd5,
        OP_WAIT = 3'd6,
        OP_RSV  = 3'd7
    } op_e;

    // Registered state
    logic [AW-1:0]   addr_q,   addr_d;
    logic [NIRQ-1:0] pend_q,   pend_d;
    logic [NIRQ-1:0] iack_q,   iack_d;
    logic            intact_q, intact_d;
    logic [DW-1:0]   depth_q,  depth_d;
    logic            ovf_q,    ovf_d;
    logic            unf_q,    unf_d;
    logic [AW-1:0]   stk_q [SD];
    logic [AW-1:0]   stk_d [SD];

    // Decoded instruction and interrupt selection
    op_e             op;
    logic [AW-1:0]   addr_inc;
    logic [AW-1:0]   pop_val;
    logic [AW-1:0]   op_next;
    logic [AW-1:0]   op_ret;
    logic            op_push;
    logic            op_pop;
    logic            op_iret;
    logic            irq_hit;
    logic [NIRQ-1:0] irq_onehot;
    logic [AW-1:0]   irq_vec;
    logic            take_irq;
    logic            do_push;
    logic            do_pop;
    logic [AW-1:0]   push_val;

    assign op = op_e'(OP);

    // Lowest-numbered enabled pending request wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        irq_hit    = 1'b0;
        irq_onehot = '0;
        irq_vec    = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && IMASK[i]) begin
                irq_hit       = 1'b1;
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
                irq_vec       = AW'(VBASE + 2 * i);
            end
        end
    end

    assign take_irq = EN && !intact_q && irq_hit;

    // op_next is where the OP itself goes; op_ret is what an interrupt entry
    // saves in its place (WAIT resumes past itself rather than re-waiting).
    always_comb begin
        addr_inc = addr_q + AW'(1);
        pop_val  = (depth_q == '0) ? '0 : stk_q[0];
        op_next  = addr_inc;
        op_ret   = addr_inc;
        op_push  = 1'b0;
        op_pop   = 1'b0;
        op_iret  = 1'b0;
        case (op)
            OP_JMP: begin
                op_next = TARGET;
                op_ret  = TARGET;
            end
            OP_JCC: begin
                if (COND) begin
                    op_next = TARGET;
                    op_ret  = TARGET;
                end
            end
            OP_CALL: begin
                op_next = TARGET;
                op_ret  = TARGET;
                op_push = 1'b1;
            end
            OP_RET: begin
                op_next = pop_val;
                op_ret  = pop_val;
                op_pop  = 1'b1;
            end
            OP_IRET: begin
                op_next = pop_val;
                op_ret  = pop_val;
                op_pop  = 1'b1;
                op_iret = 1'b1;
            end
            OP_WAIT: begin
                op_next = addr_q;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        intact_d = intact_q;
        iack_d   = '0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_val = addr_inc;
        if (EN) begin
            if (take_irq) begin
                addr_d   = irq_vec;
                intact_d = 1'b1;
                iack_d   = irq_onehot;
                do_push  = 1'b1;
                push_val = op_ret;
            end else begin
                addr_d  = op_next;
                do_push = op_push;
                do_pop  = op_pop;
                if (op_iret) begin
                    intact_d = 1'b0;
                end
            end
        end
        // A new request on the bit being acknowledged keeps it pending.
        pend_d = (pend_q & ~(take_irq ? irq_onehot : '0)) | REQ;
    end

    // Stack is a shift register with the top at index 0, so an overflowing
    // push drops the deepest entry off the far end.
    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (do_push) begin
            for (int i = SD - 1; i > 0; i--) begin
                stk_d[i] = stk_q[i-1];
            end
            stk_d[0] = push_val;
            if (depth_q == DW'(SD)) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (do_pop) begin
            for (int i = 0; i < SD - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[SD-1] = '0;
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            addr_q   <= '0;
            pend_q   <= '0;
            iack_q   <= '0;
            intact_q <= 1'b0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            // NOTE: the stack array is cleared on reset, so a pop from an empty stack never exposes stale data.
            for (int i = 0; i < SD; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            iack_q   <= iack_d;
            intact_q <= intact_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            stk_q    <= stk_d;
        end
    end

    assign ADDR   = addr_q;
    assign IACK   = iack_q;
    assign INTACT = intact_q;
    assign DEPTH  = depth_q;
    assign OVF    = ovf_q;
    assign UNF    = unf_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed and randomized bench for mc_sequencer; a queue-based model of the
// sequencer rules supplies every expected value.
module tb_mc_sequencer;

    localparam int AW    = 11;
    localparam int SD    = 4;
    localparam int NIRQ  = 8;
    localparam int ASZ   = 1 << AW;
    localparam int VBASE = ASZ - 2 * NIRQ;

    logic            clk;
    logic            rst;
    logic            en;
    logic [2:0]      op;
    logic [AW-1:0]   target;
    logic            cond;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] imask;
    logic [AW-1:0]   addr;
    logic [NIRQ-1:0] iack;
    logic            intact;
    logic [2:0]      depth;
    logic            ovf;
    logic            unf;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int unsigned     m_addr;
    logic [NIRQ-1:0] m_pend;
    logic [NIRQ-1:0] m_iack;
    bit              m_intact;
    bit              m_ovf;
    bit              m_unf;
    int unsigned     m_stk[$];

    mc_sequencer #(.AW(AW), .SD(SD), .NIRQ(NIRQ)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .EN     (en),
        .OP     (op),
        .TARGET (target),
        .COND   (cond),
        .REQ    (req),
        .IMASK  (imask),
        .ADDR   (addr),
        .IACK   (iack),
        .INTACT (intact),
        .DEPTH  (depth),
        .OVF    (ovf),
        .UNF    (unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int unsigned v);
        if (m_stk.size() == SD) begin
            void'(m_stk.pop_back());
            m_ovf = 1'b1;
        end
        m_stk.push_front(v);
    endtask

    task automatic model_pop(output int unsigned v);
        if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            v = 0;
        end else begin
            v = m_stk.pop_front();
        end
    endtask

    // One rising edge of the sequencer, applied to the model.
    task automatic model_edge();
        logic [NIRQ-1:0] avail;
        logic [NIRQ-1:0] clr;
        int unsigned     inc;
        int unsigned     would;
        int unsigned     v;
        int              k;
        if (rst) begin
            m_addr = 0; m_pend = '0; m_iack = '0;
            m_intact = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_stk.delete();
            return;
        end
        clr    = '0;
        m_iack = '0;
        inc    = (m_addr + 1) % ASZ;
        if (en) begin
            avail = m_pend & imask;
            if (!m_intact && avail != '0) begin
                k = 0;
                while (!avail[k]) k++;
                case (op)
                    3'd1, 3'd3: would = target;
                    3'd2:       would = cond ? int'(target) : inc;
                    3'd4, 3'd5: would = (m_stk.size() == 0) ? 0 : m_stk[0];
                    default:    would = inc;
                endcase
                model_push(would);
                m_addr   = (VBASE + 2 * k) % ASZ;
                m_intact = 1'b1;
                m_iack   = NIRQ'(1 << k);
                clr[k]   = 1'b1;
            end else begin
                case (op)
                    3'd1: m_addr = target;
                    3'd2: m_addr = cond ? int'(target) : inc;
                    3'd3: begin model_push(inc); m_addr = target; end
                    3'd4: begin model_pop(v); m_addr = v; end
                    3'd5: begin model_pop(v); m_addr = v; m_intact = 1'b0; end
                    3'd6: m_addr = m_addr;
                    default: m_addr = inc;
                endcase
            end
        end
        m_pend = (m_pend & ~clr) | req;
    endtask

    task automatic compare_all();
        check("addr",   32'(addr),   m_addr);
        check("iack",   32'(iack),   32'(m_iack));
        check("intact", 32'(intact), 32'(m_intact));
        check("depth",  32'(depth),  m_stk.size());
        check("ovf",    32'(ovf),    32'(m_ovf));
        check("unf",    32'(unf),    32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic e, input logic [2:0] o, input logic [AW-1:0] t);
        en = e; op = o; target = t;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; target = '0; cond = 1'b0;
        req = '0; imask = '0;
        m_addr = 0; m_pend = '0; m_iack = '0;
        m_intact = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset state, then first INC after release
        tick();
        tick();
        check("reset_addr", 32'(addr), 32'h0);
        rst = 1'b0;
        drive(1'b1, 3'd0, '0);
        tick();
        check("first_inc", 32'(addr), 32'h1);

        // Branching: JMP, CALL, RET
        drive(1'b1, 3'd1, 11'h100); tick();
        check("jmp", 32'(addr), 32'h100);
        drive(1'b1, 3'd3, 11'h200); tick();
        check("call", 32'(addr), 32'h200);
        drive(1'b1, 3'd4, '0); tick();
        check("ret_addr", 32'(addr), 32'h101);
        check("ret_depth", 32'(depth), 32'h0);
        cond = 1'b0; drive(1'b1, 3'd2, 11'h3AA); tick();
        check("jcc_false", 32'(addr), 32'h102);
        cond = 1'b1; drive(1'b1, 3'd2, 11'h101); tick();
        check("jcc_true", 32'(addr), 32'h101);

        // Overflow and underflow
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd3, AW'(11'h300 + 16 * i)); tick();
        end
        check("ovf_depth", 32'(depth), 32'h4);
        check("ovf_flag", 32'(ovf), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd4, '0); tick();
            check("ovf_ret", 32'(addr), 32'(11'h331 - 16 * i));
        end
        drive(1'b1, 3'd4, '0); tick();
        check("unf_addr", 32'(addr), 32'h0);
        check("unf_flag", 32'(unf), 32'h1);
        drive(1'b1, 3'd0, '0); tick();
        check("sticky_ovf", 32'(ovf), 32'h1);

        // Interrupt entry, lowest index first, no nesting
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 3'd1, 11'h010); tick();
        drive(1'b0, 3'd0, '0); req = 8'h28; imask = 8'hFF; tick();
        check("stall_hold", 32'(addr), 32'h010);
        req = '0;
        drive(1'b1, 3'd0, '0); tick();
        check("irq_addr", 32'(addr), 32'h7F6);
        check("irq_iack", 32'(iack), 32'h08);
        check("irq_intact", 32'(intact), 32'h1);
        tick();
        check("iack_pulse", 32'(iack), 32'h0);
        drive(1'b1, 3'd5, '0); tick();
        check("iret_addr", 32'(addr), 32'h011);
        drive(1'b1, 3'd0, '0); tick();
        check("irq2_addr", 32'(addr), 32'h7FA);
        drive(1'b1, 3'd5, '0); tick();
        check("iret2_addr", 32'(addr), 32'h012);

        // Masked request during WAIT
        drive(1'b1, 3'd1, 11'h020); tick();
        imask = 8'h00; req = 8'h04; drive(1'b1, 3'd6, '0); tick();
        req = '0;
        for (int i = 0; i < 3; i++) tick();
        check("wait_hold", 32'(addr), 32'h020);
        imask = 8'h04; tick();
        check("wait_irq", 32'(addr), 32'h7F4);
        drive(1'b1, 3'd5, '0); tick();
        check("wait_iret", 32'(addr), 32'h021);

        // Request during a stall, then reset inside the handler
        imask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'd0, '0);
            req = (i == 2) ? 8'h01 : 8'h00;
            tick();
        end
        req = '0;
        check("stall_addr", 32'(addr), 32'h021);
        drive(1'b1, 3'd0, '0); tick();
        check("stall_irq", 32'(addr), 32'h7F0);
        drive(1'b1, 3'd3, 11'h050); tick();
        rst = 1'b1; tick();
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_intact", 32'(intact), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        rst = 1'b0;

        // Request coinciding with its own acknowledge stays pending
        drive(1'b0, 3'd0, '0); req = 8'h02; tick();
        drive(1'b1, 3'd0, '0); tick();
        req = '0;
        drive(1'b1, 3'd5, '0); tick();
        drive(1'b1, 3'd0, '0); tick();
        check("set_wins", 32'(addr), 32'h7F2);

        // Randomized traffic
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            en     = ($urandom_range(0, 9) != 0);
            op     = 3'($urandom_range(0, 7));
            target = AW'($urandom);
            cond   = 1'($urandom);
            req    = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom) : '0;
            imask  = NIRQ'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
